servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_multi.sv | 91 +++++++++
 tb/tb_servo_pwm_multi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with shadowed pulse widths,
// clamped channel targets and an optional per-period slew limit.
module servo_pwm_multi #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 32,
    parameter int PERIOD    = 1000000,
    parameter int MIN_PULSE = 50000,
    parameter int MAX_PULSE = 100000,
    parameter int STEP      = 0,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_clk,
    input  logic                reset_low,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_pulse,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] at_target,
    output logic                period_start,
    output logic                high,
    output logic                gnd
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] MID_P  = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
    localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target [CHANNELS];
    logic [CNT_W-1:0] active [CHANNELS];
    logic             update;

    function automatic logic [CNT_W-1:0] clamp_pulse(input logic [CNT_W-1:0] p);
        if (p < MIN_P)
            return MIN_P;
        if (p > MAX_P)
            return MAX_P;
        return p;
    endfunction

    // Distance is compared before stepping so the result never passes the target.
    function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] act,
                                              input logic [CNT_W-1:0] tgt);
        if (STEP == 0)
            return tgt;
        if (tgt > act)
            return ((tgt - act) > STEP_W) ? act + STEP_W : tgt;
        return ((act - tgt) > STEP_W) ? act - STEP_W : tgt;
    endfunction

    assign high   = 1'b1;
    assign gnd    = 1'b0;
    assign update = !enable || (cnt == LAST);

    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            cnt          <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                target[n] <= MID_P;
                active[n] <= MID_P;
            end
        end else begin
            if (!enable || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            period_start <= enable && (cnt == '0);

            for (int n = 0; n < CHANNELS; n++) begin
                pwm_out[n] <= enable && (cnt < active[n]);
                if (update)
                    active[n] <= slew(active[n], target[n]);
                if (wr_en && int'(wr_ch) == n)
                    target[n] <= clamp_pulse(wr_pulse);
            end
        end
    end

    always_comb begin
        at_target = '0;
        for (int n = 0; n < CHANNELS; n++)
            at_target[n] = (active[n] == target[n]);
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a 4-channel STEP=0 build and a 3-channel STEP=2 build,
// each with a per-period width monitor popping expected records from a queue.
module tb_servo_pwm_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, wr_en_a;
    logic [1:0]  wr_ch_a;
    logic [15:0] wr_pulse_a;
    logic [3:0]  pwm_a, at_a;
    logic        ps_a, high_a, gnd_a;

    logic        rst_b, en_b, wr_en_b;
    logic [1:0]  wr_ch_b;
    logic [15:0] wr_pulse_b;
    logic [2:0]  pwm_b, at_b;
    logic        ps_b, high_b, gnd_b;

    servo_pwm_multi #(.CHANNELS(4), .CNT_W(16), .PERIOD(100), .MIN_PULSE(10),
                      .MAX_PULSE(20), .STEP(0)) dut_a (
        .clock_clk(clk), .reset_low(rst_a), .enable(en_a), .wr_en(wr_en_a),
        .wr_ch(wr_ch_a), .wr_pulse(wr_pulse_a), .pwm_out(pwm_a), .at_target(at_a),
        .period_start(ps_a), .high(high_a), .gnd(gnd_a));

    servo_pwm_multi #(.CHANNELS(3), .CNT_W(16), .PERIOD(100), .MIN_PULSE(10),
                      .MAX_PULSE(20), .STEP(2)) dut_b (
        .clock_clk(clk), .reset_low(rst_b), .enable(en_b), .wr_en(wr_en_b),
        .wr_ch(wr_ch_b), .wr_pulse(wr_pulse_b), .pwm_out(pwm_b), .at_target(at_b),
        .period_start(ps_b), .high(high_b), .gnd(gnd_b));

    typedef struct {
        logic [3:0][7:0] w;
        logic [3:0]      at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req)
            passes++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic exp_t mk(input int w0, input int w1, input int w2, input int w3,
                                input logic [3:0] at);
        exp_t e;
        e.w[0] = 8'(w0);
        e.w[1] = 8'(w1);
        e.w[2] = 8'(w2);
        e.w[3] = 8'(w3);
        e.at   = at;
        return e;
    endfunction

    // Widths are high-cycle counts over one period; at_target is the value seen
    // on the period's first cycle.
    task automatic finish_period(input int id, input logic [3:0][7:0] got,
                                 input int cyc, input logic [3:0] at_s);
        exp_t e;
        int   empty;
        empty = (id == 0) ? (qa.size() == 0) : (qb.size() == 0);
        if (empty != 0) begin
            checks++;
            $display("FAIL dut%0d unexpected period: widths %h, no expectation queued", id, got);
        end else begin
            e = (id == 0) ? qa.pop_front() : qb.pop_front();
            for (int i = 0; i < 4; i++)
                chk($sformatf("dut%0d ch%0d width", id, i), int'(got[i]), int'(e.w[i]));
            chk($sformatf("dut%0d at_target", id), int'(at_s), int'(e.at));
            chk($sformatf("dut%0d period length", id), cyc, 100);
        end
    endtask

    initial begin : mon_a
        logic [3:0][7:0] acc;
        logic [3:0]      ats;
        int              cyc;
        bit              prog;
        prog = 0;
        cyc  = 0;
        acc  = '0;
        ats  = '0;
        forever begin
            @(negedge clk);
            if (!rst_a || !en_a) begin
                prog = 0;
            end else if (ps_a) begin
                if (prog)
                    finish_period(0, acc, cyc, ats);
                prog = 1;
                cyc  = 1;
                ats  = at_a;
                for (int i = 0; i < 4; i++)
                    acc[i] = 8'(pwm_a[i]);
            end else if (prog) begin
                cyc++;
                for (int i = 0; i < 4; i++)
                    acc[i] = acc[i] + 8'(pwm_a[i]);
            end
        end
    end

    initial begin : mon_b
        logic [3:0][7:0] acc;
        logic [3:0]      ats;
        int              cyc;
        bit              prog;
        prog = 0;
        cyc  = 0;
        acc  = '0;
        ats  = '0;
        forever begin
            @(negedge clk);
            if (!rst_b || !en_b) begin
                prog = 0;
            end else if (ps_b) begin
                if (prog)
                    finish_period(1, acc, cyc, ats);
                prog = 1;
                cyc  = 1;
                ats  = {1'b0, at_b};
                acc  = '0;
                for (int i = 0; i < 3; i++)
                    acc[i] = 8'(pwm_b[i]);
            end else if (prog) begin
                cyc++;
                for (int i = 0; i < 3; i++)
                    acc[i] = acc[i] + 8'(pwm_b[i]);
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge where period_start is high (counter register is 1).
    task automatic wait_ps(input int id);
        bit seen;
        seen = 0;
        for (int i = 0; i < 250 && !seen; i++) begin
            @(negedge clk);
            if ((id == 0) ? ps_a : ps_b)
                seen = 1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL dut%0d period_start: none within 250 cycles", id);
        end
    endtask

    task automatic wr(input int id, input int ch, input int val);
        if (id == 0) begin
            wr_en_a    = 1'b1;
            wr_ch_a    = 2'(ch);
            wr_pulse_a = 16'(val);
        end else begin
            wr_en_b    = 1'b1;
            wr_ch_b    = 2'(ch);
            wr_pulse_b = 16'(val);
        end
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b1; wr_en_a = 1'b0; wr_ch_a = '0; wr_pulse_a = '0;
        rst_b = 1'b0; en_b = 1'b1; wr_en_b = 1'b0; wr_ch_b = '0; wr_pulse_b = '0;
        gap(3);

        chk("reset pwm_out", int'(pwm_a), 0);
        chk("reset period_start", int'(ps_a), 0);
        chk("reset at_target", int'(at_a), 15);
        chk("high", int'(high_a), 1);
        chk("gnd", int'(gnd_a), 0);

        // Power-up widths, then clamped writes landing mid-period.
        qa.push_back(mk(15, 15, 15, 15, 4'hF));
        rst_a = 1'b1;
        wait_ps(0);
        gap(49); wr(0, 2, 18);
        gap(9);  wr(0, 1, 5);
        gap(9);  wr(0, 0, 50);
        qa.push_back(mk(20, 10, 18, 15, 4'hF));
        wait_ps(0);

        // Write at counter 98 lands next period; write at 99 lands one later.
        gap(97); wr(0, 2, 11); wr(0, 3, 12);
        qa.push_back(mk(20, 10, 11, 15, 4'b0111));
        wait_ps(0);
        qa.push_back(mk(20, 10, 11, 12, 4'hF));
        wait_ps(0);
        wait_ps(0);

        // Drop enable at counter 5, re-enable 30 cycles later.
        gap(4);
        en_a = 1'b0;
        @(negedge clk);
        chk("disable pwm_out", int'(pwm_a), 0);
        chk("disable period_start", int'(ps_a), 0);
        qa.push_back(mk(20, 10, 11, 12, 4'hF));
        gap(29);
        en_a = 1'b1;
        @(negedge clk);
        chk("reenable period_start", int'(ps_a), 1);
        chk("reenable pwm_out", int'(pwm_a), 15);
        wait_ps(0);
        rst_a = 1'b0;

        // Slew-limited 3-channel build.
        chk("b reset at_target", int'(at_b), 7);
        chk("b reset pwm_out", int'(pwm_b), 0);
        chk("b high", int'(high_b), 1);
        chk("b gnd", int'(gnd_b), 0);
        qb.push_back(mk(15, 15, 15, 0, 4'b0111));
        rst_b = 1'b1;
        wait_ps(1);
        gap(9); wr(1, 0, 20);
        gap(8); wr(1, 3, 40);
        qb.push_back(mk(17, 15, 15, 0, 4'b0110));
        wait_ps(1);
        qb.push_back(mk(19, 15, 15, 0, 4'b0110));
        wait_ps(1);
        qb.push_back(mk(20, 15, 15, 0, 4'b0111));
        wait_ps(1);
        gap(9); wr(1, 0, 10);
        wait_ps(1);

        // Reset in the middle of a downward slew (active now 18, target 10).
        gap(9);
        chk("b mid-slew at_target", int'(at_b), 6);
        chk("b mid-slew pwm_out", int'(pwm_b), 7);
        #2 rst_b = 1'b0;
        #1;
        chk("b async reset pwm_out", int'(pwm_b), 0);
        chk("b async reset at_target", int'(at_b), 7);
        chk("b async reset period_start", int'(ps_b), 0);
        @(negedge clk);
        gap(2);
        qb.push_back(mk(15, 15, 15, 0, 4'b0111));
        rst_b = 1'b1;
        wait_ps(1);
        wait_ps(1);
        gap(2);

        chk("dut0 leftover expectations", qa.size(), 0);
        chk("dut1 leftover expectations", qb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
